kmac_encode_stream: RTL and testbench
=====================================

// Module: kmac_encode_stream
// PURPOSE
//  Byte-serial NIST SP 800-185 integer encoder for the KMAC datapath.
//  Accepts one unsigned integer x per transaction and emits right_encode(x) or left_encode(x), one byte per beat.
//  Output uses a valid/ready handshake and feeds the KMAC message/padding assembler, e.g. right_encode(L) after M
//  and left_encode(rate) for bytepad.
//  Generalises the fixed 4-byte pad generator: the value width is parametrised, n is computed on the fly,
//  both encodings are supported, and back-pressure is supported.
// PARAMETERS
//  VAL_W   64   width of x in bits; multiple of 8, 8..2040 (elaboration-time $error otherwise)
//  MAX_N   VAL_W/8   derived localparam; maximum byte count n, always <= 255
//  CNT_W   $clog2(MAX_N+1)   derived localparam; width of n and of the byte index
// PORTS
//  clk        in   1       clock, rising edge
//  rst_n      in   1       asynchronous active-low reset
//  in_valid   in   1       request carries a valid x
//  in_ready   out  1       encoder idle and able to accept x
//  in_value   in   VAL_W   integer x, unsigned
//  in_left    in   1       1 = left_encode (n first); 0 = right_encode (n last)
//  out_valid  out  1       out_byte is valid
//  out_ready  in   1       downstream accepts the byte
//  out_byte   out  8       encoded byte
//  out_last   out  1       final byte of the encoding; qualified by out_valid
//  busy       out  1       transaction in progress (state != IDLE)
// BEHAVIOUR
//  Reset values: in_ready=1, out_valid=0, out_byte=0, out_last=0, busy=0; state=IDLE, counters 0.
//  Reset is asynchronous at any time, including mid-stream. The partial encoding is abandoned; no byte is emitted after reset.
//  Byte count n:
//   - n = number of significant bytes of x, with a minimum of 1.
//   - x=0 gives n=1 and the byte 0x00.
//   - Computed combinationally from in_value at accept time and registered.
//  Value bytes are emitted big-endian, starting with byte n-1 (most significant nonzero byte), down to byte 0.
//  Encodings:
//   - left:  n, x[n-1..0], total n+1 beats
//   - right: x[n-1..0], n, total n+1 beats
//  Accept happens when in_valid && in_ready. x, mode and n are captured, and out_valid rises on the next cycle.
//  in_ready = (state==IDLE), so there is no accept while busy. A new transaction cannot start on the cycle the last byte leaves.
//  FSM:
//   - IDLE -accept-> HDR if left, VAL if right
//   - HDR (out_byte=n) -beat-> VAL
//   - VAL (out_byte = x byte idx; idx counts n-1 down to 0) -beat at idx==0-> TRL if right, IDLE if left
//   - TRL (out_byte=n) -beat-> IDLE
//  A beat is out_valid && out_ready.
//  Back-pressure: while out_valid && !out_ready, out_byte and out_last are held stable and the state does not advance.
//  out_valid never drops without a beat.
//  out_last=1 on the final beat: the last VAL byte for left, the TRL byte for right.
//  Outputs (out_valid, out_byte, out_last) are registered. Throughput is 1 byte/cycle with out_ready held high.
//  in_value/in_left are ignored when not accepted. Inputs changing during a stream have no effect.
//  With VAL_W=8, n is always 1 and the output is 2 beats.
// STRUCTURE
//  kmac_pkg:
//   - typedef enum logic {ENC_RIGHT=1'b0, ENC_LEFT=1'b1} kmac_enc_mode_t
//   - localparam KMAC_BYTE_W=8
//   - typedef enum for the FSM states {IDLE, HDR, VAL, TRL}
//  Sub-module kmac_byte_len #(VAL_W): combinational leading-nonzero-byte priority encoder, value -> n (CNT_W bits, min 1).
//  Top level: FSM, index counter, capture registers, output byte mux (x byte select).
// TESTING
//  1 right, x=0 -> 0x00, 0x01 (last); n=1.
//  2 left, x=0 -> 0x01, 0x00 (last).
//  3 right, x=256 (KMAC L) -> 0x01, 0x00, 0x02 (last); left, x=168 -> 0x01, 0xA8 (last).
//  4 left, x=64'hFFFF_FFFF_FFFF_FFFF -> 0x08 then 0xFF x8, out_last on the 9th beat.
//    Same with right and x=64'h0100_0000_0000_0000 -> 0x01, 0x00 x7, 0x08.
//  5 Back-pressure: toggle out_ready randomly during test 4.
//    - Bytes stay stable while stalled; exact sequence.
//    - in_ready stays 0 until the cycle after the last beat.
//    - in_valid held high is accepted only then.
//  6 Reset asserted after the 3rd beat of test 4 -> outputs immediately at reset values.
//    After release, test 1 encodes correctly. Also rerun tests 1-3 with VAL_W=16 and VAL_W=8.

Source files
------------

// File: rtl/kmac_pkg.sv
// Shared types for the KMAC integer encoder: encoding mode, byte width and encoder FSM states.
package kmac_pkg;

  localparam int KMAC_BYTE_W = 8;

  typedef enum logic {
    ENC_RIGHT = 1'b0,
    ENC_LEFT  = 1'b1
  } kmac_enc_mode_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HDR  = 2'd1,
    VAL  = 2'd2,
    TRL  = 2'd3
  } kmac_enc_state_t;

endpackage

// File: rtl/kmac_byte_len.sv
// Leading-nonzero-byte priority encoder: number of significant bytes of value, minimum 1.
module kmac_byte_len
  import kmac_pkg::*;
#(
  parameter int VAL_W = 64,
  parameter int CNT_W = $clog2(VAL_W / 8 + 1)
) (
  input  logic [VAL_W-1:0] value,
  output logic [CNT_W-1:0] n
);

  localparam int MAX_N = VAL_W / KMAC_BYTE_W;

  logic [MAX_N-1:0] byte_nz;

  genvar gi;
  generate
    for (gi = 0; gi < MAX_N; gi++) begin : g_nz
      assign byte_nz[gi] = |value[gi*KMAC_BYTE_W +: KMAC_BYTE_W];
    end
  endgenerate

  // Highest nonzero byte wins; an all-zero value still occupies one byte.
  always_comb begin
    n = CNT_W'(1);
    for (int i = 1; i < MAX_N; i++) begin
      if (byte_nz[i]) n = CNT_W'(i + 1);
    end
  end

endmodule

// File: rtl/kmac_encode_stream.sv
// Byte-serial SP 800-185 left_encode/right_encode generator with valid/ready output.
module kmac_encode_stream
  import kmac_pkg::*;
#(
  parameter int VAL_W = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [VAL_W-1:0] in_value,
  input  logic             in_left,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [7:0]       out_byte,
  output logic             out_last,
  output logic             busy
);

  localparam int MAX_N = VAL_W / KMAC_BYTE_W;
  localparam int CNT_W = $clog2(MAX_N + 1);

  generate
    if ((VAL_W % 8) != 0 || VAL_W < 8 || VAL_W > 2040) begin : g_bad_width
      $error("kmac_encode_stream: VAL_W must be a multiple of 8 in 8..2040");
    end
  endgenerate

  kmac_enc_state_t  state_reg, state_next;
  kmac_enc_mode_t   mode_reg, mode_next;
  logic [VAL_W-1:0] x_reg, x_next;
  logic [CNT_W-1:0] n_reg, n_next;
  logic [CNT_W-1:0] idx_reg, idx_next;
  logic             out_valid_reg, out_valid_next;
  logic [7:0]       out_byte_reg, out_byte_next;
  logic             out_last_reg, out_last_next;
  logic [CNT_W-1:0] len_n;
  logic [7:0]       sel_byte;
  logic             accept;
  logic             beat;

  kmac_byte_len #(
    .VAL_W(VAL_W),
    .CNT_W(CNT_W)
  ) u_byte_len (
    .value(in_value),
    .n    (len_n)
  );

  assign in_ready  = (state_reg == IDLE);
  assign busy      = (state_reg != IDLE);
  assign accept    = in_valid && in_ready;
  assign beat      = out_valid_reg && out_ready;
  assign out_valid = out_valid_reg;
  assign out_byte  = out_byte_reg;
  assign out_last  = out_last_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      mode_reg      <= ENC_RIGHT;
      x_reg         <= '0;
      n_reg         <= '0;
      idx_reg       <= '0;
      out_valid_reg <= 1'b0;
      out_byte_reg  <= '0;
      out_last_reg  <= 1'b0;
    end else begin
      state_reg     <= state_next;
      mode_reg      <= mode_next;
      x_reg         <= x_next;
      n_reg         <= n_next;
      idx_reg       <= idx_next;
      out_valid_reg <= out_valid_next;
      out_byte_reg  <= out_byte_next;
      out_last_reg  <= out_last_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    mode_next  = mode_reg;
    x_next     = x_reg;
    n_next     = n_reg;
    idx_next   = idx_reg;
    unique case (state_reg)
      IDLE: begin
        if (accept) begin
          x_next     = in_value;
          n_next     = len_n;
          mode_next  = kmac_enc_mode_t'(in_left);
          idx_next   = len_n - CNT_W'(1);
          state_next = in_left ? HDR : VAL;
        end
      end
      HDR: begin
        if (beat) state_next = VAL;
      end
      VAL: begin
        if (beat) begin
          if (idx_reg == '0) begin
            state_next = (mode_reg == ENC_LEFT) ? IDLE : TRL;
          end else begin
            idx_next = idx_reg - CNT_W'(1);
          end
        end
      end
      TRL: begin
        if (beat) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Outputs are derived from the upcoming state so they can be registered without a bubble.
  always_comb begin
    sel_byte = '0;
    for (int i = 0; i < MAX_N; i++) begin
      if (idx_next == CNT_W'(i)) sel_byte = x_next[i*KMAC_BYTE_W +: KMAC_BYTE_W];
    end
  end

  always_comb begin
    out_valid_next = (state_next != IDLE);
    out_byte_next  = '0;
    out_last_next  = 1'b0;
    unique case (state_next)
      HDR: out_byte_next = 8'(n_next);
      VAL: begin
        out_byte_next = sel_byte;
        out_last_next = (mode_next == ENC_LEFT) && (idx_next == '0);
      end
      TRL: begin
        out_byte_next = 8'(n_next);
        out_last_next = 1'b1;
      end
      default: out_byte_next = '0;
    endcase
  end

endmodule

// File: tb/tb_kmac_encode_stream.sv
// Bench for kmac_encode_stream: three widths (64/16/8) checked against a queue-based encoding model.
module tb_kmac_encode_stream;

  logic        clk;
  logic        rst_n;
  logic        iv   [3];
  logic        il   [3];
  logic [63:0] ival [3];
  logic        ordy [3];
  logic        ir   [3];
  logic        ov   [3];
  logic [7:0]  ob   [3];
  logic        ol   [3];
  logic        bs   [3];
  logic        rnd_ready;

  int total = 0;
  int bad = 0;
  logic [7:0] exp_q [3][$];

  kmac_encode_stream #(.VAL_W(64)) u_dut64 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[0]), .in_ready(ir[0]), .in_value(ival[0]),
    .in_left(il[0]), .out_valid(ov[0]), .out_ready(ordy[0]), .out_byte(ob[0]),
    .out_last(ol[0]), .busy(bs[0]));

  kmac_encode_stream #(.VAL_W(16)) u_dut16 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[1]), .in_ready(ir[1]), .in_value(ival[1][15:0]),
    .in_left(il[1]), .out_valid(ov[1]), .out_ready(ordy[1]), .out_byte(ob[1]),
    .out_last(ol[1]), .busy(bs[1]));

  kmac_encode_stream #(.VAL_W(8)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[2]), .in_ready(ir[2]), .in_value(ival[2][7:0]),
    .in_left(il[2]), .out_valid(ov[2]), .out_ready(ordy[2]), .out_byte(ob[2]),
    .out_last(ol[2]), .busy(bs[2]));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) begin
    #1;
    ordy[0] = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    ordy[1] = 1'b1;
    ordy[2] = 1'b1;
  end

  task automatic chk(input string name, input int id, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s inst=%0d got=%0h expected=%0h t=%0t", name, id, act, exp, $time);
    end
  endtask

  // Model: n = significant bytes (min 1); left puts n first, right puts n last; value bytes MSB first.
  function automatic int encode(input logic [63:0] x, input logic left, output logic [7:0] b [9]);
    int n;
    int k;
    n = 1;
    k = 0;
    for (int i = 0; i < 9; i++) b[i] = 8'h00;
    for (int i = 1; i < 8; i++) if ((x >> (8 * i)) != 64'd0) n = i + 1;
    if (left) begin b[k] = 8'(n); k++; end
    for (int i = n - 1; i >= 0; i--) begin
      b[k] = 8'((x >> (8 * i)) & 64'hFF);
      k++;
    end
    if (!left) begin b[k] = 8'(n); k++; end
    return k;
  endfunction

  task automatic pin(input string name, input logic [63:0] x, input logic left,
                     input int len, input logic [7:0] e [9]);
    logic [7:0] b [9];
    int k;
    k = encode(x, left, b);
    chk({name, "_len"}, 9, k, len);
    for (int i = 0; i < len; i++) chk({name, "_byte"}, 9, b[i], e[i]);
  endtask

  // One compare process: every negedge, every instance is held against the model queue.
  always @(negedge clk) begin
    for (int id = 0; id < 3; id++) begin
      if (!rst_n) begin
        chk("rst_in_ready", id, ir[id], 1);
        chk("rst_out_valid", id, ov[id], 0);
        chk("rst_out_byte", id, ob[id], 0);
        chk("rst_out_last", id, ol[id], 0);
        chk("rst_busy", id, bs[id], 0);
        exp_q[id].delete();
      end else begin
        int sz;
        sz = exp_q[id].size();
        chk("in_ready", id, ir[id], (sz == 0) ? 1 : 0);
        chk("busy", id, bs[id], (sz != 0) ? 1 : 0);
        chk("out_valid", id, ov[id], (sz != 0) ? 1 : 0);
        if (ov[id] && sz != 0) begin
          chk("out_byte", id, ob[id], exp_q[id][0]);
          chk("out_last", id, ol[id], (sz == 1) ? 1 : 0);
          if (ordy[id]) void'(exp_q[id].pop_front());
        end
        if (iv[id] && ir[id]) begin
          logic [7:0] b [9];
          int k;
          k = encode(ival[id], il[id], b);
          for (int i = 0; i < k; i++) exp_q[id].push_back(b[i]);
          $display("txn inst=%0d x=%0h left=%0b beats=%0d", id, ival[id], il[id], k);
        end
      end
    end
  end

  task automatic send(input int id, input logic [63:0] x, input logic left);
    int t;
    t = 0;
    ival[id] = x;
    il[id] = left;
    iv[id] = 1'b1;
    do begin
      @(negedge clk);
      t++;
    end while (!ir[id] && t < 200);
    if (!ir[id]) chk("accept_timeout", id, 0, 1);
    @(posedge clk);
    #1;
    iv[id] = 1'b0;
    ival[id] = {$urandom, $urandom};
    il[id] = 1'($urandom_range(0, 1));
  endtask

  task automatic wait_done(input int id);
    int t;
    t = 0;
    while (!(exp_q[id].size() == 0 && ir[id] && !ov[id]) && t < 300) begin
      @(negedge clk);
      t++;
    end
    if (t >= 300) chk("drain_timeout", id, 0, 1);
    @(posedge clk);
    #1;
  endtask

  initial begin
    int cnt;
    rst_n = 1'b0;
    rnd_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      iv[i] = 1'b0;
      il[i] = 1'b0;
      ival[i] = 64'd0;
    end

    pin("m_r0", 64'd0, 1'b0, 2, '{8'h00, 8'h01, 0, 0, 0, 0, 0, 0, 0});
    pin("m_l0", 64'd0, 1'b1, 2, '{8'h01, 8'h00, 0, 0, 0, 0, 0, 0, 0});
    pin("m_r256", 64'd256, 1'b0, 3, '{8'h01, 8'h00, 8'h02, 0, 0, 0, 0, 0, 0});
    pin("m_l168", 64'd168, 1'b1, 2, '{8'h01, 8'hA8, 0, 0, 0, 0, 0, 0, 0});
    pin("m_lff", 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 9,
        '{8'h08, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF});
    pin("m_r01", 64'h0100_0000_0000_0000, 1'b0, 9,
        '{8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h08});

    #21 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Tests 1-4 at VAL_W=64
    send(0, 64'd0, 1'b0);                   wait_done(0);
    send(0, 64'd0, 1'b1);                   wait_done(0);
    send(0, 64'd256, 1'b0);                 wait_done(0);
    send(0, 64'd168, 1'b1);                 wait_done(0);
    send(0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1); wait_done(0);
    send(0, 64'h0100_0000_0000_0000, 1'b0); wait_done(0);

    // Test 5: random back-pressure, with the next request held high behind each stream
    rnd_ready = 1'b1;
    send(0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1);
    send(0, 64'h0100_0000_0000_0000, 1'b0);
    send(0, 64'h0000_0012_3456_789A, 1'b1);
    wait_done(0);
    rnd_ready = 1'b0;
    @(posedge clk);
    #1;

    // Narrow widths
    send(1, 64'd0, 1'b0);    wait_done(1);
    send(1, 64'd0, 1'b1);    wait_done(1);
    send(1, 64'd256, 1'b0);  wait_done(1);
    send(1, 64'd168, 1'b1);  wait_done(1);
    send(1, 64'hBEEF, 1'b1); wait_done(1);
    send(2, 64'd0, 1'b0);    wait_done(2);
    send(2, 64'd0, 1'b1);    wait_done(2);
    send(2, 64'd168, 1'b1);  wait_done(2);
    send(2, 64'd255, 1'b0);  wait_done(2);

    // Test 6: asynchronous reset after the 3rd beat of a 9-beat stream
    send(0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1);
    cnt = 0;
    for (int t = 0; t < 50 && cnt < 3; t++) begin
      @(negedge clk);
      if (ov[0] && ordy[0]) cnt++;
    end
    chk("beats_before_reset", 0, cnt, 3);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_valid", 0, ov[0], 0);
    chk("async_rst_byte", 0, ob[0], 0);
    chk("async_rst_last", 0, ol[0], 0);
    chk("async_rst_ready", 0, ir[0], 1);
    chk("async_rst_busy", 0, bs[0], 0);
    @(negedge clk);
    @(negedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;
    send(0, 64'd0, 1'b0);
    wait_done(0);
    send(0, 64'd256, 1'b0);
    wait_done(0);

    repeat (3) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
